mtf_neuron_bank: RTL and testbench
==================================

// Module: mtf_neuron_bank
// PURPOSE
//  Time-multiplexed bank of N_NEURONS multiple-timescale-feedback (MTF) neurons with N_FB filtered-voltage feedback currents each.
//  Signed fixed-point state; one shared saturating MAC is stepped by an FSM.
//  One accepted step request advances every neuron by one Euler step.
//  Sits between the CPG pattern controller (drives i_ext and step) and the spike/servo mapping logic.
// PARAMETERS
//  N_NEURONS  4   neurons in bank
//  N_FB       3   feedback timescales per neuron (fast/slow/ultraslow)
//  DW         16  data width, signed two's complement
//  FRAC       8   fractional bits (Q(DW-FRAC).FRAC)
//  REFR_STEPS 2   refractory length in steps (used only with MTF_REFRACTORY_EN)
// PORTS
//  clk        in  1              clock
//  reset      in  1              synchronous, active-high
//  step_valid in  1              request one update sweep
//  step_ready out 1              high only in IDLE
//  i_ext      in  N_NEURONS*DW   external current per neuron, signed
//  thresh     in  DW             spike threshold, signed
//  alpha      in  N_FB*DW        feedback gain per timescale, signed
//  delta      in  N_FB*DW        feedback offset per timescale, signed
//  tau_shift  in  N_FB*4         filter time constant per timescale as right-shift
//  tm_shift   in  4              membrane time constant as right-shift
//  done       out 1              one-cycle pulse when sweep results are visible
//  spike      out N_NEURONS      per-neuron crossing flag, held until next done
//  voltage    out N_NEURONS*DW   membrane voltage per neuron, held until next done
// BEHAVIOUR
//  Reset: v, all v_k, shadow outputs, spike, done = 0. FSM enters IDLE; step_ready=1 from first cycle after reset.
//  Reset mid-sweep aborts the sweep and clears all state.
//  Accept: step_valid&&step_ready. All inputs latched that cycle; later input changes do not affect the sweep.
//  step_valid while busy is ignored (no queueing).
//  FSM: IDLE -> ACCUM (k=0..N_FB-1, one cycle each) -> UPDATE.
//    From UPDATE: next neuron -> ACCUM; after last neuron -> DONE -> IDLE.
//  Latency: done asserted exactly N_NEURONS*(N_FB+1)+1 cycles after the accept cycle.
//  ACCUM k: f_k = sat((alpha_k*(v_k-delta_k)) >>> FRAC); acc = sat(acc + f_k).
//  UPDATE (all terms use pre-step v):
//    v' = sat(v + sat(i_ext - v - acc) >>> tm_shift)
//    v_k' = sat(v_k + ((v - v_k) >>> tau_shift_k))
//  Arithmetic: products are 2*DW wide; arithmetic right shift; every add saturates to [-2^(DW-1), 2^(DW-1)-1], never wraps.
//  Shift value 0 is legal (full step). Shifts >= DW yield 0 or -1 per sign.
//  Spike: spike[n] = (v < thresh) && (v' >= thresh), i.e. upward crossing only. Staying above threshold gives 0.
//  Outputs: voltage and spike update together in the DONE cycle only. Stable in between.
// CONFIGURATION
//  MTF_REFRACTORY_EN defined:
//    - per-neuron counter loaded with REFR_STEPS on spike;
//    - while counter != 0, v' = 0 and spike = 0, and the counter decrements each step;
//    - v_k filters keep updating.
//  MTF_REFRACTORY_EN undefined: no counters, no hold; REFR_STEPS ignored.
// STRUCTURE
//  Package mtf_pkg:
//    - FSM state enum (IDLE, ACCUM, UPDATE, DONE);
//    - sat() function parameterised by DW;
//    - default FRAC constant.
//  Sub-module mtf_sat_mac: shared signed multiply, arithmetic shift by FRAC, saturating accumulate.
//  State arrays and FSM stay in mtf_neuron_bank.
// TESTING (DW=16, FRAC=8, N_NEURONS=4, N_FB=3 unless stated)
//  1. Reset then idle -> voltage=0, spike=0, done=0, step_ready=1. A second reset during a sweep returns the same.
//  2. i_ext[0]=0x0800, alpha=0, tm_shift=3, one step -> voltage[0]=0x0100; done exactly 17 cycles after accept.
//  3. thresh=0x0080, same stimulus, two steps:
//     step 1 -> spike[0]=1; step 2 -> voltage[0]=0x01E0, spike[0]=0.
//  4. i_ext[1]=0x7FFF, tm_shift=0, repeated steps -> voltage[1] stays 0x7FFF (no wrap).
//     alpha[0]=0x7FFF with v_0 large -> clamps, never flips sign.
//  5. step_valid held high during sweep -> exactly one done per accept. Inputs changed mid-sweep do not alter the result.
//  6. MTF_REFRACTORY_EN, REFR_STEPS=2, crossing stimulus -> spike, then voltage=0 for 2 steps, then resumes integrating.

Source files
------------

// File: rtl/mtf_pkg.sv
// Shared types and helpers for the MTF neuron bank: FSM state encoding,
// default fixed-point fraction and a width-parameterised saturation function.
package mtf_pkg;

  localparam int FRAC_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/mtf_neuron_bank_if.sv
// Step handshake, parameter bus and result bus of the MTF neuron bank.
// master = pattern controller side, slave = neuron bank.
interface mtf_neuron_bank_if #(
  parameter int N_NEURONS = 4,
  parameter int N_FB      = 3,
  parameter int DW        = 16
);
  logic                    step_valid;
  logic                    step_ready;
  logic [N_NEURONS*DW-1:0] i_ext;
  logic [DW-1:0]           thresh;
  logic [N_FB*DW-1:0]      alpha;
  logic [N_FB*DW-1:0]      delta;
  logic [N_FB*4-1:0]       tau_shift;
  logic [3:0]              tm_shift;
  logic                    done;
  logic [N_NEURONS-1:0]    spike;
  logic [N_NEURONS*DW-1:0] voltage;

  modport master (
    output step_valid, i_ext, thresh, alpha, delta, tau_shift, tm_shift,
    input  step_ready, done, spike, voltage
  );

  modport slave (
    input  step_valid, i_ext, thresh, alpha, delta, tau_shift, tm_shift,
    output step_ready, done, spike, voltage
  );
endinterface

// File: rtl/mtf_sat_mac.sv
// Shared saturating MAC: acc_out = sat(acc_in + sat((coef * x) >>> FRAC)).
// Purely combinational; the bank registers the accumulator.
module mtf_sat_mac
  import mtf_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic signed [DW-1:0] coef,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] acc_in,
  output logic signed [DW-1:0] acc_out
);
  logic signed [2*DW-1:0] prod;
  logic signed [63:0]     term;
  logic signed [63:0]     sum;

  always_comb begin
    prod    = (2*DW)'(coef) * (2*DW)'(x);
    term    = sat(64'(prod) >>> FRAC, DW);
    sum     = sat(64'(acc_in) + term, DW);
    acc_out = DW'(sum);
  end
endmodule

// File: rtl/mtf_neuron_bank.sv
// Time-multiplexed bank of MTF neurons sharing one saturating MAC.
// Optional refractory hold is enabled by defining MTF_REFRACTORY_EN.
module mtf_neuron_bank
  import mtf_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int N_FB       = 3,
  parameter int DW         = 16,
  parameter int FRAC       = FRAC_DEFAULT,
  parameter int REFR_STEPS = 2
) (
  input logic           clk,
  input logic           reset,
  mtf_neuron_bank_if.slave bus
);
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int KW = (N_FB > 1) ? $clog2(N_FB) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(N_NEURONS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_FB - 1);

  state_t                state_reg;
  logic [NW-1:0]         n_reg;
  logic [KW-1:0]         k_reg;
  logic signed [DW-1:0]  acc_reg;
  logic signed [DW-1:0]  acc_next;
  logic signed [DW-1:0]  v_reg   [N_NEURONS];
  logic signed [DW-1:0]  vk_reg  [N_NEURONS][N_FB];

  logic signed [DW-1:0]  i_ext_in  [N_NEURONS];
  logic signed [DW-1:0]  i_ext_reg [N_NEURONS];
  logic signed [DW-1:0]  alpha_in  [N_FB];
  logic signed [DW-1:0]  alpha_reg [N_FB];
  logic signed [DW-1:0]  delta_in  [N_FB];
  logic signed [DW-1:0]  delta_reg [N_FB];
  logic [3:0]            tau_in    [N_FB];
  logic [3:0]            tau_reg   [N_FB];
  logic signed [DW-1:0]  thresh_reg;
  logic [3:0]            tm_reg;

  logic [N_NEURONS-1:0]  spike_pend_reg;
  logic [N_NEURONS-1:0]  spike_reg;
  logic signed [DW-1:0]  voltage_reg [N_NEURONS];
  logic                  done_reg;
  logic                  ready_reg;

  logic signed [63:0]    vk_sel_w;
  logic signed [DW-1:0]  mac_x;
  logic signed [63:0]    v_w;
  logic signed [63:0]    inner_w;
  logic signed [63:0]    v_sum_w;
  logic signed [DW-1:0]  v_int;
  logic signed [DW-1:0]  v_new;
  logic signed [DW-1:0]  vk_new [N_FB];
  logic                  spike_new;
  logic                  in_refr;

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      assign i_ext_in[gi]                = bus.i_ext[gi*DW +: DW];
      assign bus.voltage[gi*DW +: DW]    = voltage_reg[gi];
    end
    // Filter updates for all timescales of the current neuron run in parallel.
    for (gi = 0; gi < N_FB; gi++) begin : g_fb
      logic signed [63:0] vk_w;
      logic signed [63:0] vk_sum_w;
      assign alpha_in[gi] = bus.alpha[gi*DW +: DW];
      assign delta_in[gi] = bus.delta[gi*DW +: DW];
      assign tau_in[gi]   = bus.tau_shift[gi*4 +: 4];
      assign vk_w         = 64'(vk_reg[n_reg][gi]);
      assign vk_sum_w     = sat(vk_w + ((v_w - vk_w) >>> tau_reg[gi]), DW);
      assign vk_new[gi]   = DW'(vk_sum_w);
    end
  endgenerate

  assign vk_sel_w = 64'(vk_reg[n_reg][k_reg]);
  assign mac_x    = DW'(sat(vk_sel_w - 64'(delta_reg[k_reg]), DW));

  mtf_sat_mac #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_mac (
    .coef    (alpha_reg[k_reg]),
    .x       (mac_x),
    .acc_in  (acc_reg),
    .acc_out (acc_next)
  );

  // Membrane update from pre-step v and the finished feedback sum.
  assign v_w     = 64'(v_reg[n_reg]);
  assign inner_w = sat(64'(i_ext_reg[n_reg]) - v_w - 64'(acc_reg), DW);
  assign v_sum_w = sat(v_w + (inner_w >>> tm_reg), DW);
  assign v_int   = DW'(v_sum_w);

`ifdef MTF_REFRACTORY_EN
  localparam int RW = (REFR_STEPS > 0) ? $clog2(REFR_STEPS + 1) : 1;
  logic [RW-1:0] refr_reg [N_NEURONS];
  assign in_refr = (refr_reg[n_reg] != '0);
`else
  assign in_refr = 1'b0;
`endif

  assign v_new     = in_refr ? '0 : v_int;
  assign spike_new = !in_refr && (v_reg[n_reg] < thresh_reg) && (v_int >= thresh_reg);

  assign bus.step_ready = ready_reg;
  assign bus.done       = done_reg;
  assign bus.spike      = spike_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      n_reg          <= '0;
      k_reg          <= '0;
      acc_reg        <= '0;
      thresh_reg     <= '0;
      tm_reg         <= '0;
      spike_pend_reg <= '0;
      spike_reg      <= '0;
      done_reg       <= 1'b0;
      ready_reg      <= 1'b1;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_reg[i]       <= '0;
        i_ext_reg[i]   <= '0;
        voltage_reg[i] <= '0;
`ifdef MTF_REFRACTORY_EN
        refr_reg[i]    <= '0;
`endif
        for (int k = 0; k < N_FB; k++) vk_reg[i][k] <= '0;
      end
      for (int k = 0; k < N_FB; k++) begin
        alpha_reg[k] <= '0;
        delta_reg[k] <= '0;
        tau_reg[k]   <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.step_valid) begin
            for (int i = 0; i < N_NEURONS; i++) i_ext_reg[i] <= i_ext_in[i];
            for (int k = 0; k < N_FB; k++) begin
              alpha_reg[k] <= alpha_in[k];
              delta_reg[k] <= delta_in[k];
              tau_reg[k]   <= tau_in[k];
            end
            thresh_reg <= bus.thresh;
            tm_reg     <= bus.tm_shift;
            n_reg      <= '0;
            k_reg      <= '0;
            acc_reg    <= '0;
            ready_reg  <= 1'b0;
            state_reg  <= ACCUM;
          end
        end
        ACCUM: begin
          acc_reg <= acc_next;
          if (k_reg == K_LAST) state_reg <= UPDATE;
          else k_reg <= k_reg + KW'(1);
        end
        UPDATE: begin
          v_reg[n_reg]          <= v_new;
          spike_pend_reg[n_reg] <= spike_new;
          for (int k = 0; k < N_FB; k++) vk_reg[n_reg][k] <= vk_new[k];
`ifdef MTF_REFRACTORY_EN
          if (in_refr) refr_reg[n_reg] <= refr_reg[n_reg] - RW'(1);
          else if (spike_new) refr_reg[n_reg] <= RW'(REFR_STEPS);
`endif
          acc_reg <= '0;
          k_reg   <= '0;
          if (n_reg == N_LAST) begin
            // Last neuron's result is still in flight, so forward it directly.
            for (int i = 0; i < N_NEURONS; i++) begin
              voltage_reg[i] <= (NW'(i) == n_reg) ? v_new : v_reg[i];
              spike_reg[i]   <= (NW'(i) == n_reg) ? spike_new : spike_pend_reg[i];
            end
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            n_reg     <= n_reg + NW'(1);
            state_reg <= ACCUM;
          end
        end
        DONE: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mtf_neuron_bank.sv
// Directed self-checking bench for mtf_neuron_bank (DW=16, FRAC=8, 4 neurons, 3 timescales).
module tb_mtf_neuron_bank;
  localparam int N  = 4;
  localparam int K  = 3;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mtf_neuron_bank_if #(.N_NEURONS(N), .N_FB(K), .DW(DW)) bus ();

  mtf_neuron_bank #(
    .N_NEURONS (N),
    .N_FB      (K),
    .DW        (DW),
    .FRAC      (8),
    .REFR_STEPS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] vout(input int n);
    return bus.voltage[n*DW +: DW];
  endfunction

  task automatic clear_inputs();
    bus.step_valid = 1'b0;
    bus.i_ext      = '0;
    bus.thresh     = 16'h7FFF;
    bus.alpha      = '0;
    bus.delta      = '0;
    bus.tau_shift  = '0;
    bus.tm_shift   = 4'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One accepted step; lat = cycles from accept to done (accept edge counts as 1).
  task automatic do_step(output int lat);
    int w;
    w = 0;
    while (!bus.step_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    bus.step_valid = 1'b1;
    @(posedge clk); #1;
    bus.step_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.done) begin
      checks++; failures++;
      $display("FAIL step_timeout: no done within %0d cycles, required done=1", lat);
    end
    $display("step lat=%0d voltage=%h spike=%b", lat, bus.voltage, bus.spike);
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    checks++; if (bus.voltage !== '0) begin failures++; $display("FAIL reset_voltage: got %h want 0", bus.voltage); end
    checks++; if (bus.spike !== '0) begin failures++; $display("FAIL reset_spike: got %b want 0", bus.spike); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.step_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.step_ready); end
  endtask

  task automatic test_basic();
    int lat;
    apply_reset();
    bus.i_ext[0 +: 16] = 16'h0800;
    bus.tm_shift       = 4'd3;
    do_step(lat);
    checks++; if (lat != 17) begin failures++; $display("FAIL basic_latency: got %0d want 17", lat); end
    checks++; if (vout(0) !== 16'h0100) begin failures++; $display("FAIL basic_v0: got %h want 0100", vout(0)); end
    checks++; if (bus.voltage[16 +: 48] !== '0) begin failures++; $display("FAIL basic_v_others: got %h want 0", bus.voltage[16 +: 48]); end
    checks++; if (bus.spike !== 4'b0000) begin failures++; $display("FAIL basic_spike: got %b want 0000", bus.spike); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    checks++; if (bus.step_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back: got %b want 1", bus.step_ready); end
  endtask

  task automatic test_spike();
    int lat;
    apply_reset();
    bus.i_ext[0 +: 16] = 16'h0800;
    bus.tm_shift       = 4'd3;
    bus.thresh         = 16'h0080;
    do_step(lat);
    checks++; if (bus.spike !== 4'b0001) begin failures++; $display("FAIL spike_step1: got %b want 0001", bus.spike); end
    checks++; if (vout(0) !== 16'h0100) begin failures++; $display("FAIL spike_v_step1: got %h want 0100", vout(0)); end
    do_step(lat);
    checks++; if (vout(0) !== 16'h01E0) begin failures++; $display("FAIL spike_v_step2: got %h want 01E0", vout(0)); end
    checks++; if (bus.spike !== 4'b0000) begin failures++; $display("FAIL spike_step2: got %b want 0000", bus.spike); end
  endtask

  // Starts from the non-zero state left by test_spike.
  task automatic test_reset_mid_sweep();
    int lat;
    int extra;
    bus.step_valid = 1'b1;
    @(posedge clk); #1;
    bus.step_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bus.voltage !== '0) begin failures++; $display("FAIL midrst_voltage: got %h want 0", bus.voltage); end
    checks++; if (bus.spike !== '0) begin failures++; $display("FAIL midrst_spike: got %b want 0", bus.spike); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    checks++; if (bus.step_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b want 1", bus.step_ready); end
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL midrst_stray_done: got %0d want 0", extra); end
    do_step(lat);
    checks++; if (vout(0) !== 16'h0100) begin failures++; $display("FAIL midrst_fresh_v0: got %h want 0100", vout(0)); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [15:0] want [3];
    apply_reset();
    bus.i_ext[16 +: 16] = 16'h7FFF;
    bus.i_ext[32 +: 16] = 16'h8000;
    for (int s = 0; s < 3; s++) begin
      do_step(lat);
      checks++; if (vout(1) !== 16'h7FFF) begin failures++; $display("FAIL sat_pos step%0d: got %h want 7FFF", s, vout(1)); end
      checks++; if (vout(2) !== 16'h8000) begin failures++; $display("FAIL sat_neg step%0d: got %h want 8000", s, vout(2)); end
    end
    // Feedback product 0x7FFF*0x7FFF must clamp to +0x7FFF, not wrap negative.
    apply_reset();
    bus.i_ext[0 +: 16] = 16'h7FFF;
    bus.alpha[0 +: 16] = 16'h7FFF;
    want[0] = 16'h7FFF; want[1] = 16'h7FFF; want[2] = 16'h0000;
    for (int s = 0; s < 3; s++) begin
      do_step(lat);
      checks++; if (vout(0) !== want[s]) begin failures++; $display("FAIL sat_fb step%0d: got %h want %h", s, vout(0), want[s]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int first;
    int extra;
    int lat;
    apply_reset();
    bus.i_ext[0 +: 16] = 16'h0800;
    bus.tm_shift       = 4'd3;
    bus.step_valid     = 1'b1;
    @(posedge clk); #1;
    cyc = 1; first = 0;
    while (first == 0 && cyc < 60) begin
      if (cyc == 8) begin
        bus.i_ext[0 +: 16] = 16'h4000;
        bus.tm_shift       = 4'd0;
      end
      if (bus.done) first = cyc;
      else begin
        @(posedge clk); #1; cyc++;
      end
    end
    bus.step_valid = 1'b0;
    checks++; if (first != 17) begin failures++; $display("FAIL b2b_latency: got %0d want 17", first); end
    checks++; if (vout(0) !== 16'h0100) begin failures++; $display("FAIL b2b_latched_v0: got %h want 0100", vout(0)); end
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL b2b_extra_done: got %0d want 0", extra); end
    do_step(lat);
    checks++; if (vout(0) !== 16'h4000) begin failures++; $display("FAIL b2b_new_inputs_v0: got %h want 4000", vout(0)); end
  endtask

`ifdef MTF_REFRACTORY_EN
  task automatic test_refractory();
    int lat;
    logic [15:0] want_v [4];
    logic [3:0]  want_s [4];
    apply_reset();
    bus.i_ext[0 +: 16] = 16'h0800;
    bus.tm_shift       = 4'd3;
    bus.thresh         = 16'h0080;
    want_v[0] = 16'h0100; want_s[0] = 4'b0001;
    want_v[1] = 16'h0000; want_s[1] = 4'b0000;
    want_v[2] = 16'h0000; want_s[2] = 4'b0000;
    want_v[3] = 16'h0100; want_s[3] = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      do_step(lat);
      checks++; if (vout(0) !== want_v[s]) begin failures++; $display("FAIL refr_v step%0d: got %h want %h", s, vout(0), want_v[s]); end
      checks++; if (bus.spike !== want_s[s]) begin failures++; $display("FAIL refr_spike step%0d: got %b want %b", s, bus.spike, want_s[s]); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_spike();
    test_reset_mid_sweep();
    test_saturation();
    test_back_to_back();
`ifdef MTF_REFRACTORY_EN
    test_refractory();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
